rotate_check: RTL and testbench
===============================

# rotate_check

Sequential rotation validator that sits directly downstream of the combinational 4×4 rotation stage. On request it rotates the current falling-piece mask, then checks the result against the 10×20 board one row per cycle, trying column kicks 0, −1 and +1 in that order. It returns either the committed mask and x position, or a rejection, to the game controller.

## Interface
Parameters:
- COLS, 10, board width in columns
- ROWS, 20, board height in rows

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req  in  1  single-cycle request pulse; sampled only in IDLE
- float  in  [0:15]  current piece mask; bit i*4+j is row i, column j; bit 0 is top-left
- direction  in  1  0 = clockwise, 1 = counter-clockwise
- pos_x  in  5  signed (two's complement) board column of mask column 0
- pos_y  in  5  unsigned board row of mask row 0
- board_row_addr  out  5  board row being read; combinational from state
- board_row  in  [0:COLS-1]  occupancy of the addressed row, valid in the same cycle; bit c is column c
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse when the result is valid
- ok  out  1  1 = rotation accepted; held until the next done
- out_float  out  [0:15]  result mask; held until the next done
- out_x  out  5  result column; held until the next done

## Operation
- Rotation, computed once at acceptance and latched as rot:
  - Clockwise: rot[i*4+j] = float[j*4+3−i].
  - Counter-clockwise: rot[i*4+j] = float[(3−j)*4+i].
- The original float, pos_x and pos_y are also latched at acceptance.
- States:
  - IDLE: on req, latch inputs; kick index k=0, row r=0; go to CHECK.
  - CHECK: test row r of rot at column x = pos_x + kick[k], where kick = {0, −1, +1}.
  - DONE: pulse done, update results, return to IDLE.
- Row test in CHECK:
  - board_row_addr = pos_y + r, 5-bit.
  - Collision if any set bit rot[r*4+j] lands on column x+j < 0 or x+j ≥ COLS.
  - Collision if the address is ≥ ROWS and the row r nibble is nonzero.
  - Collision if board_row[x+j] = 1 for any set bit.
  - An all-zero row never collides.
- Transitions out of CHECK:
  - No collision and r<3: r+1.
  - No collision and r=3: success with kick[k]; go to DONE.
  - Collision and k<2: k+1, r=0 (early abort of that kick).
  - Collision and k=2: reject; go to DONE.
- Results loaded in DONE:
  - Success: ok=1, out_float=rot, out_x=pos_x+kick[k].
  - Reject: ok=0, out_float=latched float, out_x=latched pos_x.
- Arithmetic: column sums use 6-bit signed; out_x wraps to 5 bits.

## Timing
- Reset values: busy=0, done=0, ok=0, out_float=0, out_x=0, board_row_addr=0; state IDLE.
- Cycle 0 is the req edge. CHECK occupies cycles 1..N, DONE (done=1) is cycle N+1, and IDLE resumes at cycle N+2.
- busy is high during cycles 1..N+1.
- Minimum latency: 4 checks, done at cycle 5.
- Maximum latency: 12 checks, done at cycle 13.
- req while busy is ignored and not queued. req in the IDLE cycle right after done is accepted.
- Board contents must not change while busy; the block does not detect changes.
- rst mid-operation returns to IDLE immediately and clears all outputs; the result is discarded.

## Test plan
- Empty board, float=16'h4444, direction=0, pos_x=0, pos_y=5 -> done at cycle 5, ok=1, out_float=16'h00F0, out_x=0.
- Empty board, same piece, pos_x=7: kick 0 fails on r=2 at cycle 3; kick −1 passes in cycles 4–7 -> done at cycle 8, ok=1, out_x=6.
- Empty board, pos_x=−1: kick 0 and kick −1 each fail on r=2 -> done at cycle 11, ok=1, out_x=0.
- Board row 7 all ones, pos_x=3, pos_y=5: every kick fails on r=2 -> done at cycle 10, ok=0, out_float=16'h4444, out_x=3.
- Direction=1 on 16'h00F0 at pos_x=0, pos_y=0 -> out_float=16'h2222, ok=1. A second req at cycle 2 is ignored: exactly one done pulse.
- rst pulse at cycle 3 of any request -> busy=0 and done=0 from the rst edge, no done pulse follows. A new req after rst completes normally.

Source files
------------

// File: rtl/rotate_check.sv
// Rotates a 4x4 piece mask and validates it against the board one row per cycle,
// trying column kicks 0, -1, +1 before rejecting.
module rotate_check #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req,
    input  logic [0:15]     i_float,
    input  logic            i_direction,
    input  logic [4:0]      i_pos_x,
    input  logic [4:0]      i_pos_y,
    output logic [4:0]      o_board_row_addr,
    input  logic [0:COLS-1] i_board_row,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_ok,
    output logic [0:15]     o_out_float,
    output logic [4:0]      o_out_x
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [0:15] r_rot;
    logic [0:15] r_float;
    logic [4:0]  r_pos_x;
    logic [4:0]  r_pos_y;
    logic [1:0]  r_k;
    logic [1:0]  r_r;

    logic [0:15]       w_rot_cw;
    logic [0:15]       w_rot_ccw;
    logic signed [5:0] w_kick;
    logic signed [5:0] w_x;
    logic [0:3]        w_nibble;
    logic [4:0]        w_addr;
    logic              w_collide;

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            assign w_rot_cw[gi*4+gj]  = i_float[gj*4+3-gi];
            assign w_rot_ccw[gi*4+gj] = i_float[(3-gj)*4+gi];
        end
    end

    always_comb begin
        case (r_k)
            2'd1:    w_kick = -6'sd1;
            2'd2:    w_kick = 6'sd1;
            default: w_kick = 6'sd0;
        endcase
    end

    assign w_x      = $signed({r_pos_x[4], r_pos_x}) + w_kick;
    assign w_nibble = r_rot[{r_r, 2'b00} +: 4];
    assign w_addr   = r_pos_y + {3'b000, r_r};

    assign o_board_row_addr = (r_state == S_CHECK) ? w_addr : 5'd0;

    // A set mask bit collides off either side, below the board, or on an occupied cell.
    always_comb begin
        w_collide = 1'b0;
        if (int'(w_addr) >= ROWS && (|w_nibble)) begin
            w_collide = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            if (w_nibble[j]) begin
                if (int'(w_x) + j < 0 || int'(w_x) + j >= COLS) begin
                    w_collide = 1'b1;
                end
                for (int c = 0; c < COLS; c++) begin
                    if (int'(w_x) + j == c && i_board_row[c]) begin
                        w_collide = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rot       <= '0;
            r_float     <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_k         <= '0;
            r_r         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_ok        <= 1'b0;
            o_out_float <= '0;
            o_out_x     <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_rot   <= i_direction ? w_rot_ccw : w_rot_cw;
                        r_float <= i_float;
                        r_pos_x <= i_pos_x;
                        r_pos_y <= i_pos_y;
                        r_k     <= 2'd0;
                        r_r     <= 2'd0;
                        o_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!w_collide) begin
                        if (r_r == 2'd3) begin
                            o_ok        <= 1'b1;
                            o_out_float <= r_rot;
                            o_out_x     <= w_x[4:0];
                            o_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_r <= r_r + 2'd1;
                        end
                    end else if (r_k == 2'd2) begin
                        o_ok        <= 1'b0;
                        o_out_float <= r_float;
                        o_out_x     <= r_pos_x;
                        o_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k <= r_k + 2'd1;
                        r_r <= 2'd0;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_check.sv
// Randomized bench for rotate_check: a per-request reference model predicts every
// cycle (row address, busy, done, results) and one process compares each negedge.
module tb_rotate_check;
    localparam int COLS = 10;
    localparam int ROWS = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            req;
    logic            dir;
    logic [0:15]     flt;
    logic [4:0]      px;
    logic [4:0]      py;
    logic [4:0]      addr;
    logic [0:COLS-1] brow;
    logic            busy;
    logic            done;
    logic            ok;
    logic [0:15]     of;
    logic [4:0]      ox;

    logic [0:COLS-1] board_mem [0:31];
    assign brow = board_mem[addr];

    rotate_check #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_float(flt), .i_direction(dir),
        .i_pos_x(px), .i_pos_y(py), .o_board_row_addr(addr), .i_board_row(brow),
        .o_busy(busy), .o_done(done), .o_ok(ok), .o_out_float(of), .o_out_x(ox)
    );

    int tests = 0;
    int fails = 0;
    int req_issued = 0;
    int req_seen = 0;
    bit in_flight = 0;
    int cyc = 0;
    bit rst_q = 0;

    int          exp_n;
    bit          exp_ok;
    logic [0:15] exp_float;
    int          exp_x;
    int          exp_addr [0:15];
    bit          held_ok = 0;
    logic [0:15] held_float = '0;
    int          held_x = 0;
    bit          lit_en;
    int          lit_n;
    bit          lit_ok;
    logic [0:15] lit_float;
    int          lit_x;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s t=%0t cyc=%0d: got %0h expected %0h", nm, $time, cyc, act, expv);
        end
    endtask

    // A row hits if any of its set cells is below the board, off the sides, or occupied.
    function automatic bit row_hits(input logic [0:15] rot, input int r, input int x, input int a);
        bit hit;
        hit = 0;
        for (int j = 0; j < 4; j++) begin
            if (rot[r*4+j] === 1'b1) begin
                if (a >= ROWS) hit = 1;
                else if (x + j < 0 || x + j >= COLS) hit = 1;
                else if (board_mem[a][x+j]) hit = 1;
            end
        end
        return hit;
    endfunction

    task automatic issue(input logic [0:15] f, input logic d, input int x0, input int y0,
                         input bit le, input int ln, input bit lo, input logic [0:15] lf,
                         input int lx);
        logic [0:15] rot;
        int n;
        bit good;
        bit hit;
        int x;
        int xs;
        int kk [3];
        kk = '{0, -1, 1};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                rot[i*4+j] = d ? f[(3-j)*4+i] : f[j*4+3-i];
        n = 0;
        good = 0;
        xs = 0;
        for (int k = 0; k < 3 && !good; k++) begin
            x = x0 + kk[k];
            hit = 0;
            for (int r = 0; r < 4 && !hit; r++) begin
                exp_addr[n] = (y0 + r) % 32;
                n++;
                hit = row_hits(rot, r, x, (y0 + r) % 32);
            end
            if (!hit) begin
                good = 1;
                xs = x;
            end
        end
        exp_n     = n;
        exp_ok    = good;
        exp_float = good ? rot : f;
        exp_x     = good ? (xs & 31) : (x0 & 31);
        lit_en    = le;
        lit_n     = ln;
        lit_ok    = lo;
        lit_float = lf;
        lit_x     = lx;
        flt = f;
        dir = d;
        px  = 5'(x0);
        py  = 5'(y0);
        req = 1'b1;
        req_issued++;
        @(negedge clk);
        #1;
        req = 1'b0;
        flt = 16'($urandom);
        dir = 1'($urandom);
        px  = 5'($urandom);
        py  = 5'($urandom);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((in_flight || req_seen != req_issued) && g < 40) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 40) begin
            $display("FAIL wait_idle: request still busy after %0d cycles, expected done", g);
            $fatal(1, "timeout");
        end
    endtask

    // Single compare process: tracks the cycle index of the current request.
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst && !rst_q) begin
                rst_q = 1;
                #1;
                in_flight  = 0;
                req_seen   = req_issued;
                held_ok    = 0;
                held_float = '0;
                held_x     = 0;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_addr", 32'(addr), 0);
                chk("rst_ok", 32'(ok), 0);
                chk("rst_float", 32'(of), 0);
                chk("rst_x", 32'(ox), 0);
            end else begin
                rst_q = rst;
                if (rst) begin
                    in_flight  = 0;
                    req_seen   = req_issued;
                    held_ok    = 0;
                    held_float = '0;
                    held_x     = 0;
                end else if (req_seen != req_issued) begin
                    req_seen  = req_issued;
                    in_flight = 1;
                    cyc       = 1;
                end else if (in_flight) begin
                    cyc++;
                end
                if (in_flight && cyc == exp_n + 2) in_flight = 0;
                if (in_flight) begin
                    chk("busy", 32'(busy), 1);
                    chk("done", 32'(done), 32'(cyc == exp_n + 1));
                    if (cyc <= exp_n) chk("row_addr", 32'(addr), 32'(exp_addr[cyc-1]));
                    if (cyc == exp_n + 1) begin
                        chk("ok", 32'(ok), 32'(exp_ok));
                        chk("out_float", 32'(of), 32'(exp_float));
                        chk("out_x", 32'(ox), 32'(exp_x));
                        if (lit_en) begin
                            chk("model_n", 32'(exp_n), 32'(lit_n));
                            chk("model_ok", 32'(exp_ok), 32'(lit_ok));
                            chk("model_float", 32'(exp_float), 32'(lit_float));
                            chk("model_x", 32'(exp_x), 32'(lit_x));
                        end
                        $display("[TB] req %0d: done after %0d checks ok=%0d float=%h x=%0d",
                                 req_issued, exp_n, exp_ok, exp_float, exp_x);
                        held_ok    = exp_ok;
                        held_float = exp_float;
                        held_x     = exp_x;
                    end else begin
                        chk("hold_ok", 32'(ok), 32'(held_ok));
                        chk("hold_float", 32'(of), 32'(held_float));
                        chk("hold_x", 32'(ox), 32'(held_x));
                    end
                end else begin
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_done", 32'(done), 0);
                    chk("idle_addr", 32'(addr), 0);
                    chk("idle_ok", 32'(ok), 32'(held_ok));
                    chk("idle_float", 32'(of), 32'(held_float));
                    chk("idle_x", 32'(ox), 32'(held_x));
                end
            end
        end
    end

    task automatic clear_board();
        for (int r = 0; r < 32; r++)
            board_mem[r] = (r < ROWS) ? '0 : COLS'($urandom);
    endtask

    task automatic random_board();
        for (int r = 0; r < 32; r++)
            board_mem[r] = (r < ROWS) ? COLS'($urandom & $urandom & $urandom) : COLS'($urandom);
    endtask

    initial begin
        logic [0:15] rf;
        int rx;
        rst = 1'b1;
        req = 1'b0;
        flt = '0;
        dir = 1'b0;
        px  = '0;
        py  = '0;
        clear_board();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;

        issue(16'h4444, 1'b0, 0, 5, 1, 4, 1, 16'h00F0, 0);
        wait_idle();
        issue(16'h4444, 1'b0, 7, 5, 1, 7, 1, 16'h00F0, 6);
        wait_idle();
        issue(16'h4444, 1'b0, -1, 5, 1, 10, 1, 16'h00F0, 0);
        wait_idle();

        board_mem[7] = '1;
        issue(16'h4444, 1'b0, 3, 5, 1, 9, 0, 16'h4444, 3);
        wait_idle();
        board_mem[7] = '0;

        // Counter-clockwise turn of the horizontal bar, plus a req while busy.
        issue(16'h00F0, 1'b1, 0, 0, 1, 4, 1, 16'h4444, 0);
        @(negedge clk);
        #1;
        req = 1'b1;
        @(negedge clk);
        #1;
        req = 1'b0;
        wait_idle();
        repeat (4) begin
            @(negedge clk);
            #1;
        end

        // Reset in the middle of a request, then a clean request.
        issue(16'h4444, 1'b0, 7, 5, 0, 0, 0, '0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        issue(16'h4444, 1'b0, 0, 5, 1, 4, 1, 16'h00F0, 0);
        wait_idle();

        for (int t = 0; t < 250; t++) begin
            if (t % 8 == 0) random_board();
            case ($urandom_range(0, 3))
                0:       rf = 16'($urandom);
                1:       rf = 16'($urandom & $urandom);
                2:       rf = 16'($urandom & $urandom & $urandom);
                default: rf = (t % 5 == 0) ? 16'h0000 : 16'h4444;
            endcase
            rx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) - 16
                                             : int'($urandom_range(0, 15)) - 3;
            issue(rf, 1'($urandom), rx, int'($urandom_range(0, 31)), 0, 0, 0, '0, 0);
            wait_idle();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    #1;
                end
            end
        end

        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
